// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen.
// master = upstream/downstream environment, slave = the window generator.
interface conv_window_gen_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                    start;
  logic [7:0]              channel_in;
  logic                    pix_valid;
  logic [DATA_WIDTH-1:0]   pix_data;
  logic                    pix_ready;
  logic                    win_valid;
  logic                    win_ready;
  logic [DATA_WIDTH*9-1:0] win_data;
  logic [7:0]              win_row;
  logic [7:0]              win_col;
  logic [7:0]              win_channel;
  logic                    frame_done;

  modport master (
    output start, channel_in, pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, win_data, win_row, win_col, win_channel, frame_done
  );

  modport slave (
    input  start, channel_in, pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, win_data, win_row, win_col, win_channel, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator with two internal line buffers.
// Emits one packed window per valid (unpadded) neighbourhood of a raster-scanned frame.
module conv_window_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 32,
  parameter int unsigned IMG_H      = 32
) (
  input logic              clk,
  input logic              rst,
  conv_window_gen_if.slave bus
);

  localparam int unsigned ColW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [7:0]  LastCol = 8'(IMG_W - 1);
  localparam logic [7:0]  LastRow = 8'(IMG_H - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e                state_q;
  logic [7:0]            row_q, col_q;
  logic [7:0]            win_row_q, win_col_q, channel_q;
  logic                  win_valid_q, frame_done_q;
  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] lb0_q [IMG_W];
  logic [DATA_WIDTH-1:0] lb1_q [IMG_W];

  logic                  pix_ready, accept, produce, last_pix;
  logic [ColW-1:0]       col_idx;
  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;

  assign col_idx   = ColW'(col_q);
  assign lb0_rd    = lb0_q[col_idx];
  assign lb1_rd    = lb1_q[col_idx];
  assign pix_ready = (state_q == StRun) && (!win_valid_q || bus.win_ready);
  assign accept    = bus.pix_valid && pix_ready;
  assign produce   = (row_q >= 8'd2) && (col_q >= 8'd2);
  assign last_pix  = (row_q == LastRow) && (col_q == LastCol);

  // Line buffers are deliberately never reset: rows 0/1 of a frame are never emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[col_idx] <= lb0_rd;
      lb0_q[col_idx] <= bus.pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      row_q        <= 8'd0;
      col_q        <= 8'd0;
      win_row_q    <= 8'd0;
      win_col_q    <= 8'd0;
      channel_q    <= 8'd0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StRun;
            row_q     <= 8'd0;
            col_q     <= 8'd0;
            channel_q <= bus.channel_in;
          end
        end
        StRun: begin
          if (accept) begin
            // Shift left; new right column is {lb1, lb0, incoming pixel} top to bottom.
            for (int r = 0; r < 3; r++) begin
              win_q[3*r]   <= win_q[3*r+1];
              win_q[3*r+1] <= win_q[3*r+2];
            end
            win_q[2] <= lb1_rd;
            win_q[5] <= lb0_rd;
            win_q[8] <= bus.pix_data;
            if (col_q == LastCol) begin
              col_q <= 8'd0;
              row_q <= row_q + 8'd1;
            end else begin
              col_q <= col_q + 8'd1;
            end
            if (last_pix) begin
              state_q <= StFlush;
            end
          end
          if (accept && produce) begin
            win_valid_q <= 1'b1;
            win_row_q   <= row_q - 8'd2;
            win_col_q   <= col_q - 8'd2;
          end else if (bus.win_ready) begin
            win_valid_q <= 1'b0;
          end
        end
        StFlush: begin
          if (win_valid_q && bus.win_ready) begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pix_ready   = pix_ready;
  assign bus.win_valid   = win_valid_q;
  assign bus.win_row     = win_row_q;
  assign bus.win_col     = win_col_q;
  assign bus.win_channel = channel_q;
  assign bus.frame_done  = frame_done_q;

  for (genvar k = 0; k < 9; k++) begin : g_pack
    assign bus.win_data[DATA_WIDTH*k +: DATA_WIDTH] = win_q[k];
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen on a 5x4 frame: window model, scoreboard
// and literal spot checks across basic, stalled, gappy, reset and back-to-back frames.
module tb_conv_window_gen;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_window_gen_if #(.DATA_WIDTH(DW)) bus ();

  conv_window_gen #(
    .DATA_WIDTH(DW),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] data;
    logic [7:0]  row;
    logic [7:0]  col;
    logic [7:0]  chan;
  } win_t;

  win_t        exp_q[$];
  logic [71:0] got_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;
  bit          chk_en   = 1'b0;
  bit          done_seen = 1'b0;
  bit          fd_exp   = 1'b0;
  bit          hold_chk = 1'b0;
  logic [95:0] hold_val;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int base, input int r, input int c);
    return 8'(base + 10 * r + c);
  endfunction

  // Window whose top-left is (wr,wc): element k = 3*i+j holds pixel (wr+i, wc+j).
  function automatic logic [71:0] win_model(input int base, input int wr, input int wc);
    logic [71:0] d;
    for (int k = 0; k < 9; k++) d[8*k +: 8] = pix(base, wr + k / 3, wc + k % 3);
    return d;
  endfunction

  task automatic push_model(input int base, input logic [7:0] chan);
    win_t e;
    for (int wr = 0; wr < H - 2; wr++) begin
      for (int wc = 0; wc < W - 2; wc++) begin
        e.data = win_model(base, wr, wc);
        e.row  = 8'(wr);
        e.col  = 8'(wc);
        e.chan = chan;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst pix_ready", 96'(bus.pix_ready), 96'd0);
    check("rst win_valid", 96'(bus.win_valid), 96'd0);
    check("rst frame_done", 96'(bus.frame_done), 96'd0);
    check("rst win_data", 96'(bus.win_data), 96'd0);
    check("rst win_row", 96'(bus.win_row), 96'd0);
    check("rst win_col", 96'(bus.win_col), 96'd0);
    check("rst win_channel", 96'(bus.win_channel), 96'd0);
  endtask

  // Compare process: scoreboard on handshakes, hold stability, frame_done timing.
  always @(negedge clk) begin
    if (chk_en) begin
      check("frame_done timing", 96'(bus.frame_done), 96'(fd_exp));
      if (bus.frame_done) begin
        done_seen = 1'b1;
        n_done++;
      end
      fd_exp = 1'b0;
      if (hold_chk) begin
        check("stall win_valid", 96'(bus.win_valid), 96'd1);
        check("stall hold", {bus.win_data, bus.win_row, bus.win_col, bus.win_channel}, hold_val);
      end
      hold_chk = bus.win_valid && !bus.win_ready;
      hold_val = {bus.win_data, bus.win_row, bus.win_col, bus.win_channel};
      if (bus.win_valid && bus.win_ready) begin
        if (exp_q.size() == 0) begin
          check("extra window", 96'd1, 96'd0);
        end else begin
          win_t e;
          e = exp_q.pop_front();
          check("win_data", 96'(bus.win_data), 96'(e.data));
          check("win_row", 96'(bus.win_row), 96'(e.row));
          check("win_col", 96'(bus.win_col), 96'(e.col));
          check("win_channel", 96'(bus.win_channel), 96'(e.chan));
          got_q.push_back(bus.win_data);
          fd_exp = (int'(e.row) == H - 3) && (int'(e.col) == W - 3);
        end
      end
    end
  end

  // vmode/rmode: 0 = always asserted, 1 = 50% random. bp stalls the first window 4 cycles.
  task automatic run_frame(input int base, input logic [7:0] chan, input int vmode,
                           input int rmode, input bit bp, input bit mid_start);
    int idx   = 0;
    int cyc   = 0;
    int stall = 0;
    bit stalling;
    bit acc;
    push_model(base, chan);
    got_q.delete();
    n_done    = 0;
    done_seen = 1'b0;
    bus.start      = 1'b1;
    bus.channel_in = chan;
    bus.pix_valid  = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    while (!done_seen && cyc < 500) begin
      bus.pix_valid = (idx < W * H) && (vmode == 0 || $urandom_range(1) == 1);
      bus.pix_data  = pix(base, idx / W, idx % W);
      stalling = bp && stall < 4 && bus.win_valid;
      if (stalling) begin
        bus.win_ready = 1'b0;
        stall++;
      end else begin
        bus.win_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(1));
      end
      bus.start      = mid_start && idx == 8;
      bus.channel_in = mid_start && idx == 8 ? 8'h55 : chan;
      @(negedge clk);
      acc = bus.pix_valid && bus.pix_ready;
      if (stalling) check("stall pix_ready", 96'(bus.pix_ready), 96'd0);
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b0;
    if (!done_seen) check("frame timeout", 96'(cyc), 96'd0);
    check("window count", 96'(got_q.size()), 96'(W - 2) * 96'(H - 2));
    check("frame_done pulses", 96'(n_done), 96'd1);
    check("scoreboard drained", 96'(exp_q.size()), 96'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [71:0] first_lit;
    logic [71:0] last_lit;
    first_lit = 72'h16_15_14_0C_0B_0A_02_01_00;
    last_lit  = 72'h22_21_20_18_17_16_0E_0D_0C;
    bus.start = 1'b0;
    bus.channel_in = 8'd0;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = '0;
    bus.win_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    chk_en = 1'b1;

    // Pin the model against hand-computed windows.
    check("model first", 96'(win_model(0, 0, 0)), 96'(first_lit));
    check("model last", 96'(win_model(0, 1, 2)), 96'(last_lit));

    // Basic frame
    run_frame(0, 8'h01, 0, 0, 1'b0, 1'b0);
    check("basic first", 96'(got_q[0]), 96'(first_lit));
    check("basic last", 96'(got_q[5]), 96'(last_lit));

    // Backpressure on the first window
    run_frame(0, 8'h02, 0, 0, 1'b1, 1'b0);
    check("bp first", 96'(got_q[0]), 96'(first_lit));

    // Gappy input and random backpressure
    run_frame(0, 8'h03, 1, 1, 1'b0, 1'b0);
    run_frame(0, 8'h04, 1, 1, 1'b0, 1'b0);

    // Channel tag with an ignored mid-frame start
    run_frame(0, 8'h2A, 0, 0, 1'b0, 1'b1);

    // Reset after 7 pixels
    bus.start = 1'b1;
    bus.channel_in = 8'h77;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.win_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = pix(50, i / W, i % W);
      @(posedge clk);
      #1;
    end
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    run_frame(0, 8'h05, 0, 0, 1'b0, 1'b0);
    check("post-reset first", 96'(got_q[0]), 96'(first_lit));
    check("post-reset last", 96'(got_q[5]), 96'(last_lit));

    // Back-to-back frames; frame 2 must hold no frame-1 values
    run_frame(0, 8'h06, 0, 0, 1'b0, 1'b0);
    run_frame(100, 8'h07, 0, 0, 1'b0, 1'b0);
    for (int w = 0; w < got_q.size(); w++) begin
      int lo = 255;
      for (int k = 0; k < 9; k++) begin
        if (int'(got_q[w][8*k +: 8]) < lo) lo = int'(got_q[w][8*k +: 8]);
      end
      check("frame2 no stale", 96'(lo >= 100), 96'd1);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
